// File: rtl/ldpc_tx_scheduler.sv
// Four-requester round-robin scheduler that encodes one byte into a 16-bit LDPC codeword and sends it over a UART line.
// Define TX_PARITY_EN to append an even-parity bit after codeword bit 15.
module ldpc_tx_scheduler #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] msg,
   output logic [3:0]  ack,
   output logic [1:0]  grant_id,
   output logic        busy,
   output logic [15:0] codeword,
   output logic        tx,
   output logic        frame_done
);

   localparam int TW = 14;
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state_reg;
   logic [TW-1:0]   bit_timer_reg;
   logic [3:0]      bit_idx_reg;
   logic [1:0]      rr_ptr_reg;
   logic [3:0]      ack_reg;
   logic [1:0]      grant_id_reg;
   logic            busy_reg;
   logic [15:0]     codeword_reg;
   logic            tx_reg;
   logic            frame_done_reg;

   logic [15:0]     cw_cand [4];
   logic [1:0]      winner;
   logic [1:0]      cand;
   logic            found;
   logic            bit_wrap;

   // Every requester's codeword is encoded in parallel; the arbiter just selects one.
   for (genvar gi = 0; gi < 4; gi++) begin : g_enc
      logic [7:0] m;
      assign m = msg[8*gi +: 8];
      assign cw_cand[gi] = {
         m,
         m[7] ^ m[5] ^ m[3] ^ m[2],
         m[6] ^ m[5] ^ m[2] ^ m[1],
         m[7] ^ m[5] ^ m[4] ^ m[1],
         m[6] ^ m[4] ^ m[3] ^ m[0],
         m[7] ^ m[5] ^ m[4] ^ m[2] ^ m[0],
         m[6] ^ m[3] ^ m[2] ^ m[1] ^ m[0],
         m[7] ^ m[4] ^ m[3] ^ m[1] ^ m[0],
         m[6] ^ m[5] ^ m[4] ^ m[1] ^ m[0]
      };
   end

   // Scan from the far end back towards rr_ptr so the closest requester wins.
   always_comb begin
      winner = 2'd0;
      found  = 1'b0;
      cand   = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         cand = rr_ptr_reg + 2'(k);
         if (req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign bit_wrap = (bit_timer_reg == TIMER_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         bit_timer_reg  <= '0;
         bit_idx_reg    <= '0;
         rr_ptr_reg     <= 2'd0;
         ack_reg        <= '0;
         grant_id_reg   <= 2'd0;
         busy_reg       <= 1'b0;
         codeword_reg   <= '0;
         tx_reg         <= 1'b1;
         frame_done_reg <= 1'b0;
      end else begin
         ack_reg        <= '0;
         frame_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               tx_reg <= 1'b1;
               // The frame_done cycle is a forced idle gap between frames.
               if (found && !frame_done_reg) begin
                  grant_id_reg  <= winner;
                  codeword_reg  <= cw_cand[winner];
                  ack_reg       <= 4'b0001 << winner;
                  rr_ptr_reg    <= winner + 2'd1;
                  state_reg     <= START;
                  busy_reg      <= 1'b1;
                  tx_reg        <= 1'b0;
                  bit_timer_reg <= '0;
                  bit_idx_reg   <= '0;
               end
            end
            START: begin
               if (bit_wrap) begin
                  bit_timer_reg <= '0;
                  bit_idx_reg   <= '0;
                  state_reg     <= DATA;
                  tx_reg        <= codeword_reg[0];
               end else begin
                  bit_timer_reg <= bit_timer_reg + 1'b1;
               end
            end
            DATA: begin
               if (bit_wrap) begin
                  bit_timer_reg <= '0;
                  if (bit_idx_reg == 4'd15) begin
`ifdef TX_PARITY_EN
                     state_reg <= PAR;
                     tx_reg    <= ^codeword_reg;
`else
                     state_reg <= STOP;
                     tx_reg    <= 1'b1;
`endif
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 4'd1;
                     tx_reg      <= codeword_reg[bit_idx_reg + 4'd1];
                  end
               end else begin
                  bit_timer_reg <= bit_timer_reg + 1'b1;
               end
            end
`ifdef TX_PARITY_EN
            PAR: begin
               if (bit_wrap) begin
                  bit_timer_reg <= '0;
                  state_reg     <= STOP;
                  tx_reg        <= 1'b1;
               end else begin
                  bit_timer_reg <= bit_timer_reg + 1'b1;
               end
            end
`endif
            STOP: begin
               tx_reg <= 1'b1;
               if (bit_wrap) begin
                  bit_timer_reg  <= '0;
                  state_reg      <= IDLE;
                  busy_reg       <= 1'b0;
                  frame_done_reg <= 1'b1;
               end else begin
                  bit_timer_reg <= bit_timer_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

   assign ack        = ack_reg;
   assign grant_id   = grant_id_reg;
   assign busy       = busy_reg;
   assign codeword   = codeword_reg;
   assign tx         = tx_reg;
   assign frame_done = frame_done_reg;

endmodule
